// File: rtl/gemv_pkg.sv
// Shared types and defaults for the GEMV tile engine: FSM state encoding,
// default parameter values and the accumulator width check.
package gemv_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FRAC_BITS   = 8;
    localparam int DEF_ACC_WIDTH   = 40;
    localparam int DEF_TILE_SIZE   = 4;
    localparam int DEF_K_TILES_MAX = 16;

    // Edges spent in FLUSH before the result is registered and presented.
    localparam int FLUSH_LAST = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_OUT
    } gemv_state_e;

    function automatic bit acc_width_ok(input int data_width, input int tile_size,
                                        input int k_tiles_max, input int acc_width);
        return acc_width >= 2 * data_width + $clog2(tile_size * k_tiles_max);
    endfunction

endpackage

// File: rtl/gemv_dot_row.sv
// One output row: registered products, full-width accumulation, then a
// registered narrowing stage. Saturating narrowing when GEMV_SAT_EN is defined.
module gemv_dot_row
    import gemv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int TILE_SIZE  = DEF_TILE_SIZE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            in_valid,
    input  logic                            y_load,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] a_row,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] x_vec,
    output logic [DATA_WIDTH-1:0]           y_out,
    output logic                            sat_out
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod_q [TILE_SIZE];
    logic signed [PW-1:0]        prod_d [TILE_SIZE];
    logic                        pv_q, pv_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] row_sum;
    logic [DATA_WIDTH-1:0]       y_q, y_d;
    logic                        sat_q, sat_d;
    logic [DATA_WIDTH-1:0]       y_narrow;
    logic                        sat_narrow;

    always_comb begin
        for (int unsigned c = 0; c < TILE_SIZE; c++) begin
            prod_d[c] = prod_q[c];
            if (in_valid) begin
                prod_d[c] = PW'($signed(a_row[c*DATA_WIDTH +: DATA_WIDTH]))
                          * PW'($signed(x_vec[c*DATA_WIDTH +: DATA_WIDTH]));
            end
            if (clr) begin
                prod_d[c] = '0;
            end
        end
        pv_d = in_valid && !clr;
    end

    always_comb begin
        row_sum = '0;
        for (int unsigned c = 0; c < TILE_SIZE; c++) begin
            row_sum = row_sum + ACC_WIDTH'(prod_q[c]);
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (pv_q) begin
            acc_d = acc_q + row_sum;
        end
    end

`ifdef GEMV_SAT_EN
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        pos_ovf, neg_ovf;

    always_comb begin
        shifted  = acc_q >>> FRAC_BITS;
        pos_ovf  = !shifted[ACC_WIDTH-1] && (shifted[ACC_WIDTH-2:DATA_WIDTH-1] != '0);
        neg_ovf  = shifted[ACC_WIDTH-1] && (shifted[ACC_WIDTH-2:DATA_WIDTH-1] != '1);
        y_narrow = shifted[DATA_WIDTH-1:0];
        if (pos_ovf) begin
            y_narrow = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (neg_ovf) begin
            y_narrow = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        sat_narrow = pos_ovf || neg_ovf;
    end
`else
    // Low bits of acc >>> FRAC_BITS, taken directly as a slice.
    assign y_narrow   = acc_q[FRAC_BITS +: DATA_WIDTH];
    assign sat_narrow = 1'b0;
`endif

    always_comb begin
        y_d   = y_q;
        sat_d = sat_q;
        if (clr) begin
            y_d   = '0;
            sat_d = 1'b0;
        end else if (y_load) begin
            y_d   = y_narrow;
            sat_d = sat_narrow;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned c = 0; c < TILE_SIZE; c++) begin
                prod_q[c] <= '0;
            end
            pv_q  <= 1'b0;
            acc_q <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < TILE_SIZE; c++) begin
                prod_q[c] <= prod_d[c];
            end
            pv_q  <= pv_d;
            acc_q <= acc_d;
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y_out   = y_q;
    assign sat_out = sat_q;

endmodule

// File: rtl/gemv_tile_engine.sv
// Tiled matrix-vector engine: streams k_tiles weight tiles per row block and
// returns one result vector. Define GEMV_SAT_EN for saturating output narrowing.
module gemv_tile_engine
    import gemv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int TILE_SIZE   = DEF_TILE_SIZE,
    parameter int K_TILES_MAX = DEF_K_TILES_MAX
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [$clog2(K_TILES_MAX+1)-1:0]          k_tiles,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [TILE_SIZE*TILE_SIZE*DATA_WIDTH-1:0] a_tile,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0]           x_slice,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [TILE_SIZE*DATA_WIDTH-1:0]           y_out,
    output logic [TILE_SIZE-1:0]                      out_sat,
    output logic                                      busy
);

    localparam int KW = $clog2(K_TILES_MAX + 1);

    if (!acc_width_ok(DATA_WIDTH, TILE_SIZE, K_TILES_MAX, ACC_WIDTH)) begin : g_acc_check
        $error("gemv_tile_engine: ACC_WIDTH too small for DATA_WIDTH/TILE_SIZE/K_TILES_MAX");
    end

    gemv_state_e   state_q, state_d;
    logic [KW-1:0] k_tiles_q, k_tiles_d;
    logic [KW-1:0] tile_cnt_q, tile_cnt_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          xfer;
    logic          row_clr;
    logic          row_y_load;

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        k_tiles_d   = k_tiles_q;
        tile_cnt_d  = tile_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_clr     = 1'b0;
        row_y_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Clearing the rows also zeroes y, which is the result for k_tiles==0.
                    row_clr     = 1'b1;
                    k_tiles_d   = k_tiles;
                    tile_cnt_d  = '0;
                    flush_cnt_d = '0;
                    state_d     = (k_tiles == '0) ? ST_OUT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    tile_cnt_d = tile_cnt_q + KW'(1);
                    if (tile_cnt_d == k_tiles_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 2'd1;
                if (flush_cnt_q == 2'(FLUSH_LAST)) begin
                    row_y_load  = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            k_tiles_q   <= '0;
            tile_cnt_q  <= '0;
            flush_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_tiles_q   <= k_tiles_d;
            tile_cnt_q  <= tile_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar r = 0; r < TILE_SIZE; r++) begin : g_row
        gemv_dot_row #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .ACC_WIDTH (ACC_WIDTH),
            .TILE_SIZE (TILE_SIZE)
        ) u_row (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (row_clr),
            .in_valid(xfer),
            .y_load  (row_y_load),
            .a_row   (a_tile[r*TILE_SIZE*DATA_WIDTH +: TILE_SIZE*DATA_WIDTH]),
            .x_vec   (x_slice),
            .y_out   (y_out[r*DATA_WIDTH +: DATA_WIDTH]),
            .sat_out (out_sat[r])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gemv_tile_engine.sv
// Scoreboard bench for gemv_tile_engine (TILE_SIZE=2, Q8.8): directed runs push
// expected results; a monitor compares on every output handshake.
module tb_gemv_tile_engine;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int AW = 40;
    localparam int TS = 2;
    localparam int KM = 16;
    localparam int KW = $clog2(KM + 1);

    typedef logic [TS*TS*DW-1:0] tile_t;
    typedef logic [TS*DW-1:0]    vec_t;

    typedef struct {
        vec_t          y;
        logic [TS-1:0] sat;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_tiles = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    tile_t         a_tile = '0;
    vec_t          x_slice = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    vec_t          y_out;
    logic [TS-1:0] out_sat;
    logic          busy;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    gemv_tile_engine #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .ACC_WIDTH  (AW),
        .TILE_SIZE  (TS),
        .K_TILES_MAX(KM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k_tiles  (k_tiles),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_tile   (a_tile),
        .x_slice  (x_slice),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got y=0x%0h with no expected entry", y_out);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_y"}, 64'(y_out), 64'(e.y));
                check({e.name, "_sat"}, 64'(out_sat), 64'(e.sat));
            end
        end
        if (!rst_n && in_valid && in_ready) begin
            n_xfer++;
        end
    end

    function automatic logic [DW-1:0] q88(input int v);
        return DW'(v * 256);
    endfunction

    function automatic tile_t mk_a(input logic [DW-1:0] a00, input logic [DW-1:0] a01,
                                   input logic [DW-1:0] a10, input logic [DW-1:0] a11);
        return {a11, a10, a01, a00};
    endfunction

    function automatic vec_t mk_v(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        return {e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input vec_t y, input logic [TS-1:0] s);
        exp_t e;
        e.y    = y;
        e.sat  = s;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic start_run(input int k);
        start   = 1'b1;
        k_tiles = KW'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic send_tile(input string name, input tile_t a, input vec_t x);
        int unsigned guard = 0;
        a_tile   = a;
        x_slice  = x;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int unsigned cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    endtask

    task automatic accept(input string name, input logic start_too);
        out_ready = 1'b1;
        start     = start_too;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, "_busy_after"}, 64'(busy), 64'(0));
        tick();
        check({name, "_idle_after"}, 64'(busy), 64'(0));
    endtask

    task automatic run2(input string name, input tile_t a0, input vec_t x0,
                        input tile_t a1, input vec_t x1, input int bub, input int hold,
                        input vec_t ey, input logic [TS-1:0] es);
        int xs;
        push_exp(name, ey, es);
        xs = n_xfer;
        start_run(2);
        send_tile(name, a0, x0);
        repeat (bub) tick();
        send_tile(name, a1, x1);
        check({name, "_flush_ready"}, 64'(in_ready), 64'(0));
        wait_out(name, 3);
        check({name, "_xfers"}, 64'(n_xfer - xs), 64'(2));
        for (int i = 0; i < hold; i++) begin
            start = (i == 1);
            tick();
            start = 1'b0;
            check({name, "_hold_y"}, 64'(y_out), 64'(ey));
            check({name, "_hold_valid"}, 64'(out_valid), 64'(1));
            check({name, "_hold_ready"}, 64'(in_ready), 64'(0));
            check({name, "_hold_busy"}, 64'(busy), 64'(1));
        end
        accept(name, hold > 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_in_ready"}, 64'(in_ready), 64'(0));
        check({name, "_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_y"}, 64'(y_out), 64'(0));
        check({name, "_sat"}, 64'(out_sat), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tile_t t0, t1, tsat, tneg;
        vec_t  v0, v1, vsat, vneg, ybase, ysat;
        logic [TS-1:0] ssat;

        t0    = mk_a(q88(1), q88(2), q88(5), q88(6));
        v0    = mk_v(q88(1), q88(2));
        t1    = mk_a(q88(3), q88(4), q88(7), q88(8));
        v1    = mk_v(q88(3), q88(4));
        ybase = mk_v(16'd7680, 16'd17920);
        tsat  = mk_a(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
        vsat  = mk_v(16'h7F00, 16'h7F00);
`ifdef GEMV_SAT_EN
        ysat = mk_v(16'h7FFF, 16'h7FFF);
        ssat = 2'b11;
`else
        ysat = mk_v(16'h0400, 16'h0400);
        ssat = 2'b00;
`endif
        tneg = mk_a(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        vneg = mk_v(16'h0001, 16'h0000);

        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b0;
        tick();

        run2("basic", t0, v0, t1, v1, 0, 0, ybase, '0);
        run2("bub1", t0, v0, t1, v1, 1, 0, ybase, '0);
        run2("bub3", t0, v0, t1, v1, 3, 0, ybase, '0);
        run2("hold", t0, v0, t1, v1, 0, 5, ybase, '0);
        run2("sat", tsat, vsat, tsat, vsat, 0, 0, ysat, ssat);

        push_exp("neg", mk_v(16'hFFFF, 16'h0000), '0);
        start_run(1);
        send_tile("neg", tneg, vneg);
        wait_out("neg", 3);
        accept("neg", 1'b0);

        run2("pre_k0", t0, v0, t1, v1, 0, 0, ybase, '0);
        push_exp("k0", '0, '0);
        start_run(0);
        check("k0_out_valid", 64'(out_valid), 64'(1));
        accept("k0", 1'b0);

        start_run(2);
        send_tile("abort", t0, v0);
        rst_n = 1'b1;
        #1;
        check_zero("midreset");
        tick();
        check_zero("midreset_hold");
        rst_n = 1'b0;
        tick();
        run2("after_reset", t0, v0, t1, v1, 0, 0, ybase, '0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gemv_tile_engine.md
GEMV_TILE_ENGINE -- requirements
Module: gemv_tile_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed Q-format element width.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of inputs and outputs.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, internal accumulator width.
REQ-004 SHALL have parameter TILE_SIZE, default 4, rows and columns per tile.
REQ-005 SHALL have parameter K_TILES_MAX, default 16, maximum tiles per row block.
REQ-006 SHALL have port clk, input, 1 bit, clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit, begin a row block; sampled only in IDLE.
REQ-009 SHALL have port k_tiles, input, $clog2(K_TILES_MAX+1) bits, tile count latched on start.
REQ-010 SHALL have port in_valid, input, 1 bit, tile and slice present.
REQ-011 SHALL have port in_ready, output, 1 bit, engine accepts a tile.
REQ-012 SHALL have port a_tile, input, TILE_SIZE*TILE_SIZE*DATA_WIDTH bits, row-major weight tile; element [r][c] at index r*TILE_SIZE+c.
REQ-013 SHALL have port x_slice, input, TILE_SIZE*DATA_WIDTH bits, vector slice.
REQ-014 SHALL have port out_valid, output, 1 bit, result vector held valid.
REQ-015 SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-016 SHALL have port y_out, output, TILE_SIZE*DATA_WIDTH bits, result vector.
REQ-017 SHALL have port out_sat, output, TILE_SIZE bits, per-row overflow flag.
REQ-018 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, FLUSH and OUT.
REQ-020 IDLE->LOAD SHALL occur on start with k_tiles>0; this transition clears the accumulators and tile counter.
REQ-021 On start with k_tiles==0, IDLE->OUT SHALL occur with y_out=0 and out_sat=0.
REQ-022 in_ready SHALL equal 1 only in LOAD; a tile transfers on in_valid&&in_ready.
REQ-023 LOAD->FLUSH SHALL occur on the transfer of tile number k_tiles; in_valid bubbles are allowed and ignored.
REQ-024 Stage 1 SHALL register the TILE_SIZE full-width signed products per row, 2*DATA_WIDTH bits each.
REQ-025 Stage 2 SHALL add the sign-extended row sum into the ACC_WIDTH accumulator with no intermediate truncation across tiles.
REQ-026 Stage 3 SHALL register y = acc >>> FRAC_BITS, an arithmetic shift that truncates toward minus infinity, narrowed per REQ-034.
REQ-027 out_valid SHALL rise after the 3rd rising edge following the last tile transfer, with FLUSH->OUT on that edge.
REQ-028 In OUT, y_out and out_sat SHALL be held stable until out_valid&&out_ready; OUT->IDLE on that edge.
REQ-029 start SHALL be ignored outside IDLE, including in the cycle OUT->IDLE completes.
REQ-030 ACC_WIDTH SHALL be at least 2*DATA_WIDTH+$clog2(TILE_SIZE*K_TILES_MAX); elaboration SHALL fail otherwise.

Reset
REQ-031 While rst_n=1, the engine SHALL set state to IDLE, clear accumulators, pipeline registers and tile counter, and drive in_ready, out_valid and busy to 0 and y_out and out_sat to 0.
REQ-032 Reset mid-operation SHALL discard all partial sums; the next run SHALL carry no stale data.

Configuration
REQ-033 Macro GEMV_SAT_EN SHALL select the output narrowing mode.
REQ-034 With GEMV_SAT_EN defined, the engine SHALL clamp y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and set out_sat[r] when row r clamps. Without it, the engine SHALL keep the low DATA_WIDTH bits (wrap), and out_sat SHALL be constant 0.

Structure
REQ-035 Package gemv_pkg SHALL hold the FSM state enum, default parameter constants and the ACC_WIDTH-check function.
REQ-036 Sub-module gemv_dot_row SHALL implement one row's product and accumulate pipeline, instantiated TILE_SIZE times.

Verification
REQ-037 Bench SHALL cover: TILE_SIZE=2, k_tiles=2, W=[1 2 3 4;5 6 7 8], x=[1 2 3 4] in Q8.8 -> y_out=[30,70] (raw 7680, 17920), out_valid 3 cycles after the last transfer.
REQ-038 Bench SHALL cover the REQ-037 data with in_valid bubbles of 1 and 3 cycles between tiles -> identical y_out and no extra transfers.
REQ-039 Bench SHALL cover out_ready held low 5 cycles in OUT with start pulsed -> y_out stable, in_ready=0, start ignored, busy=1.
REQ-040 Bench SHALL cover TILE_SIZE=2, k_tiles=2, all elements 0x7F00 -> with GEMV_SAT_EN y=0x7FFF and out_sat=2'b11; without it, y=0x0400 and out_sat=0.
REQ-041 Bench SHALL cover a single tile with a[0][0]=0xFFFF, x[0]=0x0001 and the rest 0 -> y_out[0]=0xFFFF (-1 LSB, truncation toward minus infinity).
REQ-042 Bench SHALL cover rst_n asserted after the first tile of the REQ-037 run, then a fresh REQ-037 run -> all outputs 0 during reset, then y_out=[30,70].
